// File: rtl/aes_wb_bridge_pkg.sv
// Shared types and constants for the Wishbone-to-dmem bridge feeding the AES register block.
// Includes the sel decoder used on both the request and the read-return paths.
package aes_wb_bridge_pkg;

  typedef enum logic [2:0] {IDLE, REQ, RESP, ERR, DONE} state_e;

  localparam logic [1:0] W_BYTE    = 2'b00;
  localparam logic [1:0] W_HALF    = 2'b01;
  localparam logic [1:0] W_WORD    = 2'b10;

  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_OK   = 2'b01;

  typedef struct packed {
    logic       legal;
    logic [1:0] width;
    logic [1:0] lane;
  } sel_dec_t;

  // Only naturally aligned byte, half-word and word lane patterns are accepted.
  function automatic sel_dec_t decode_sel(logic [3:0] sel);
    sel_dec_t d;
    d = '{legal: 1'b1, width: W_BYTE, lane: 2'd0};
    unique case (sel)
      4'b0001: d.lane = 2'd0;
      4'b0010: d.lane = 2'd1;
      4'b0100: d.lane = 2'd2;
      4'b1000: d.lane = 2'd3;
      4'b0011: d.width = W_HALF;
      4'b1100: begin
        d.width = W_HALF;
        d.lane  = 2'd2;
      end
      4'b1111: d.width = W_WORD;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/aes_wb_bridge_if.sv
// Wishbone slave and dmem master signals of the bridge, bundled in one interface.
// slave: the bridge's view; master: the SoC / register-block side.
interface aes_wb_bridge_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [6:0]  wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_err_o;
  logic        dmem_req;
  logic        dmem_cmd;
  logic [1:0]  dmem_width;
  logic [6:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_req_ack;
  logic [31:0] dmem_rdata;
  logic [1:0]  dmem_resp;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  dmem_req_ack, dmem_rdata, dmem_resp,
    output wbs_dat_o, wbs_ack_o, wbs_err_o,
    output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output dmem_req_ack, dmem_rdata, dmem_resp,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o,
    input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata
  );
endinterface

// File: rtl/aes_wb_sel_conv.sv
// Combinational lane converter: Wishbone lane-positioned data <-> LSB-aligned dmem data.
module aes_wb_sel_conv
  import aes_wb_bridge_pkg::*;
(
  input  logic [3:0]  fwd_sel_i,
  input  logic [31:0] wdata_i,
  output logic        legal_o,
  output logic [1:0]  width_o,
  output logic [1:0]  lane_o,
  output logic [31:0] wdata_o,
  input  logic [3:0]  rev_sel_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rdata_o
);

  sel_dec_t    fwd;
  sel_dec_t    rev;
  logic [31:0] rmask;

  always_comb begin
    fwd     = decode_sel(fwd_sel_i);
    rev     = decode_sel(rev_sel_i);
    legal_o = fwd.legal;
    width_o = fwd.width;
    lane_o  = fwd.lane;
    wdata_o = wdata_i >> {fwd.lane, 3'b000};
    unique case (rev.width)
      W_BYTE:  rmask = 32'h0000_00ff;
      W_HALF:  rmask = 32'h0000_ffff;
      default: rmask = 32'hffff_ffff;
    endcase
    // Unselected lanes return zero.
    rdata_o = (rdata_i & rmask) << {rev.lane, 3'b000};
  end

endmodule

// File: rtl/aes_wb_bridge.sv
// Wishbone slave to AES dmem bridge, one transaction in flight.
// Define AES_WB_BRIDGE_TIMEOUT_EN to abort stuck REQ/RESP phases with err after TIMEOUT_CYC.
module aes_wb_bridge
  import aes_wb_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TO_W        = 8
) (
  input logic            mclk,
  input logic            rst,
  aes_wb_bridge_if.slave bus
);

  if (64'(TIMEOUT_CYC) >= (64'd1 << TO_W)) begin : g_bad_cfg
    $error("TIMEOUT_CYC must be below 2**TO_W");
  end

  state_e      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic        cmd_q, cmd_d;
  logic [1:0]  width_q, width_d;
  logic [6:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_q, req_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdat_q, rdat_d;
  logic        abort_q, abort_d;

  logic        conv_legal;
  logic [1:0]  conv_width;
  logic [1:0]  conv_lane;
  logic [31:0] conv_wdata;
  logic [31:0] conv_rdata;
  logic        quiet;

`ifdef AES_WB_BRIDGE_TIMEOUT_EN
  logic [TO_W-1:0] cnt_q, cnt_d;
`endif

  aes_wb_sel_conv u_sel_conv (
    .fwd_sel_i (bus.wbs_sel_i),
    .wdata_i   (bus.wbs_dat_i),
    .legal_o   (conv_legal),
    .width_o   (conv_width),
    .lane_o    (conv_lane),
    .wdata_o   (conv_wdata),
    .rev_sel_i (sel_q),
    .rdata_i   (bus.dmem_rdata),
    .rdata_o   (conv_rdata)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cmd_d   = cmd_q;
    width_d = width_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    req_d   = req_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdat_d  = rdat_q;
    abort_d = abort_q;
    // Once the master abandons the cycle, the dmem side finishes silently.
    quiet   = abort_q | ~bus.wbs_cyc_i;

    unique case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
          if (conv_legal) begin
            sel_d   = bus.wbs_sel_i;
            cmd_d   = bus.wbs_we_i;
            width_d = conv_width;
            addr_d  = {bus.wbs_adr_i[6:2], conv_lane};
            wdata_d = conv_wdata;
            req_d   = 1'b1;
            state_d = REQ;
          end else begin
            err_d   = 1'b1;
            state_d = ERR;
          end
        end
      end
      REQ: begin
        abort_d = quiet;
        if (bus.dmem_req_ack) begin
          req_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        abort_d = quiet;
        if (bus.dmem_resp == RESP_OK) begin
          ack_d = ~quiet;
          if (!cmd_q) rdat_d = conv_rdata;
          state_d = DONE;
        end else if (bus.dmem_resp[1]) begin
          err_d   = ~quiet;
          state_d = DONE;
        end
      end
      ERR:     state_d = IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef AES_WB_BRIDGE_TIMEOUT_EN
    cnt_d = '0;
    if (state_q == REQ || state_q == RESP) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == TO_W'(TIMEOUT_CYC - 1) && state_d != DONE) begin
        req_d   = 1'b0;
        ack_d   = 1'b0;
        err_d   = ~quiet;
        state_d = DONE;
      end
    end
`endif
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cmd_q   <= 1'b0;
      width_q <= W_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      req_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cmd_q   <= cmd_d;
      width_q <= width_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
      abort_q <= abort_d;
    end
  end

`ifdef AES_WB_BRIDGE_TIMEOUT_EN
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  assign bus.wbs_dat_o  = rdat_q;
  assign bus.wbs_ack_o  = ack_q;
  assign bus.wbs_err_o  = err_q;
  assign bus.dmem_req   = req_q;
  assign bus.dmem_cmd   = cmd_q;
  assign bus.dmem_width = width_q;
  assign bus.dmem_addr  = addr_q;
  assign bus.dmem_wdata = wdata_q;

endmodule

// File: tb/tb_aes_wb_bridge.sv
// Self-checking bench for aes_wb_bridge: directed scenarios plus randomized transactions
// checked against a lane-arithmetic reference model.
module tb_aes_wb_bridge;

  logic mclk = 1'b0;
  logic rst  = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [31:0] exp_dat = '0;

  aes_wb_bridge_if bus ();

  aes_wb_bridge #(.TIMEOUT_CYC(8), .TO_W(8)) dut (
    .mclk (mclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 mclk = ~mclk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int lowest_lane(input logic [3:0] sel);
    int lo = 0;
    for (int i = 3; i >= 0; i--) if (sel[i]) lo = i;
    return lo;
  endfunction

  function automatic void model_fwd(input logic [3:0] sel, input logic [6:0] adr,
                                    input logic [31:0] dat, output bit legal,
                                    output logic [1:0] width, output logic [6:0] addr,
                                    output logic [31:0] wdata);
    int n  = $countones(sel);
    int lo = lowest_lane(sel);
    legal = sel inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    width = (n == 1) ? 2'b00 : (n == 2) ? 2'b01 : 2'b10;
    addr  = {adr[6:2], 2'(lo)};
    wdata = dat >> (8 * lo);
  endfunction

  function automatic logic [31:0] model_rd(input logic [3:0] sel, input logic [31:0] rd);
    int n  = $countones(sel);
    int lo = lowest_lane(sel);
    logic [63:0] v;
    v = (64'(rd) & ((64'd1 << (8 * n)) - 64'd1)) << (8 * lo);
    return v[31:0];
  endfunction

  task automatic idle_inputs();
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0; bus.wbs_sel_i = 0;
    bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
    bus.dmem_req_ack = 0; bus.dmem_rdata = 0; bus.dmem_resp = 2'b00;
  endtask

  // Full transaction with a scripted register-block response; inline checks at each phase.
  task automatic do_txn(input string nm, input logic we, input logic [6:0] adr,
                        input logic [3:0] sel, input logic [31:0] dat, input int ack_wait,
                        input int resp_wait, input logic [1:0] code, input logic [31:0] rd,
                        input bit drop);
    bit legal;
    logic [1:0] w;
    logic [6:0] a;
    logic [31:0] wd;
    bit ok_exp, err_exp;
    model_fwd(sel, adr, dat, legal, w, a, wd);
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = we;
    bus.wbs_sel_i = sel; bus.wbs_adr_i = adr; bus.wbs_dat_i = dat;
    @(negedge mclk);
    if (!legal) begin
      n_cmp++;
      if ({bus.wbs_err_o, bus.wbs_ack_o, bus.dmem_req} !== 3'b100) begin
        n_fail++;
        $display("FAIL %s illegal-sel: err/ack/req=%b required 100",
                 nm, {bus.wbs_err_o, bus.wbs_ack_o, bus.dmem_req});
      end
      bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
      @(negedge mclk);
      n_cmp++;
      if ({bus.wbs_err_o, bus.wbs_ack_o, bus.dmem_req} !== 3'b000) begin
        n_fail++;
        $display("FAIL %s illegal-after: err/ack/req=%b required 000",
                 nm, {bus.wbs_err_o, bus.wbs_ack_o, bus.dmem_req});
      end
      return;
    end
    if (drop) begin bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; end
    for (int i = 0; i <= ack_wait; i++) begin
      if (i > 0) @(negedge mclk);
      n_cmp++;
      if ({bus.dmem_req, bus.dmem_cmd, bus.dmem_width, bus.dmem_addr, bus.dmem_wdata}
          !== {1'b1, we, w, a, wd}) begin
        n_fail++;
        $display("FAIL %s req-fields c%0d: req=%b cmd=%b w=%b a=%h d=%h required 1 %b %b %h %h",
                 nm, i, bus.dmem_req, bus.dmem_cmd, bus.dmem_width, bus.dmem_addr,
                 bus.dmem_wdata, we, w, a, wd);
      end
    end
    bus.dmem_req_ack = 1;
    @(negedge mclk);
    bus.dmem_req_ack = 0;
    n_cmp++;
    if ({bus.dmem_req, bus.wbs_ack_o, bus.wbs_err_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s req-drop: req/ack/err=%b required 000",
               nm, {bus.dmem_req, bus.wbs_ack_o, bus.wbs_err_o});
    end
    for (int i = 0; i < resp_wait; i++) begin
      @(negedge mclk);
      n_cmp++;
      if ({bus.wbs_ack_o, bus.wbs_err_o} !== 2'b00) begin
        n_fail++;
        $display("FAIL %s resp-wait: ack/err=%b required 00", nm,
                 {bus.wbs_ack_o, bus.wbs_err_o});
      end
    end
    bus.dmem_resp = code; bus.dmem_rdata = rd;
    @(negedge mclk);
    bus.dmem_resp = 2'b00; bus.dmem_rdata = $urandom;
    ok_exp  = (code == 2'b01) && !drop;
    err_exp = code[1] && !drop;
    if (code == 2'b01 && !we) exp_dat = model_rd(sel, rd);
    n_cmp++;
    if ({bus.wbs_ack_o, bus.wbs_err_o} !== {ok_exp, err_exp}) begin
      n_fail++;
      $display("FAIL %s done: ack/err=%b required %b%b", nm,
               {bus.wbs_ack_o, bus.wbs_err_o}, ok_exp, err_exp);
    end
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
    @(negedge mclk);
    n_cmp++;
    if ({bus.wbs_ack_o, bus.wbs_err_o, bus.dmem_req} !== 3'b000 || bus.wbs_dat_o !== exp_dat)
    begin
      n_fail++;
      $display("FAIL %s after: ack/err/req=%b dat=%h required 000 %h", nm,
               {bus.wbs_ack_o, bus.wbs_err_o, bus.dmem_req}, bus.wbs_dat_o, exp_dat);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    @(negedge mclk);
    n_cmp++;
    if ({bus.wbs_ack_o, bus.wbs_err_o, bus.dmem_req, bus.dmem_cmd, bus.dmem_width,
         bus.dmem_addr, bus.dmem_wdata, bus.wbs_dat_o} !== '0) begin
      n_fail++;
      $display("FAIL reset: ack=%b err=%b req=%b dat=%h wdata=%h required all zero",
               bus.wbs_ack_o, bus.wbs_err_o, bus.dmem_req, bus.wbs_dat_o, bus.dmem_wdata);
    end
    rst = 0;
    @(negedge mclk);
  endtask

  task automatic test_word_write();
    // ack_wait=1 places req_ack at cycle 2, resp at 3, wbs_ack_o checked at cycle 4.
    do_txn("word_write", 1'b1, 7'h04, 4'b1111, 32'h1122_3344, 1, 0, 2'b01, 32'h0, 1'b0);
  endtask

  task automatic test_byte_read();
    do_txn("byte_read", 1'b0, 7'h24, 4'b0100, 32'h0, 1, 0, 2'b01, 32'h0000_00AB, 1'b0);
    n_cmp++;
    if (bus.wbs_dat_o !== 32'h00AB_0000) begin
      n_fail++;
      $display("FAIL byte_read_data: dat=%h required 00ab0000", bus.wbs_dat_o);
    end
  endtask

  task automatic test_half_write();
    do_txn("half_write", 1'b1, 7'h48, 4'b1100, 32'hBEEF_0000, 0, 1, 2'b01, 32'h0, 1'b0);
  endtask

  task automatic test_illegal();
    do_txn("illegal_0101", 1'b1, 7'h10, 4'b0101, 32'h55, 0, 0, 2'b01, 32'h0, 1'b0);
    do_txn("illegal_0000", 1'b0, 7'h10, 4'b0000, 32'h0, 0, 0, 2'b01, 32'h0, 1'b0);
    do_txn("illegal_0110", 1'b0, 7'h10, 4'b0110, 32'h0, 0, 0, 2'b01, 32'h0, 1'b0);
  endtask

  task automatic test_resp_err();
    do_txn("resp_err10", 1'b0, 7'h30, 4'b0011, 32'h0, 0, 2, 2'b10, 32'hFFFF_FFFF, 1'b0);
    do_txn("resp_err11", 1'b1, 7'h30, 4'b0001, 32'h7, 1, 0, 2'b11, 32'h0, 1'b0);
  endtask

  task automatic test_stall();
`ifdef AES_WB_BRIDGE_TIMEOUT_EN
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 1;
    bus.wbs_sel_i = 4'b1111; bus.wbs_adr_i = 7'h0C; bus.wbs_dat_i = 32'hCAFE_F00D;
    for (int i = 1; i <= 8; i++) begin
      @(negedge mclk);
      n_cmp++;
      if ({bus.dmem_req, bus.wbs_err_o, bus.dmem_wdata} !== {2'b10, 32'hCAFE_F00D}) begin
        n_fail++;
        $display("FAIL stall_to c%0d: req=%b err=%b wdata=%h required 1 0 cafef00d",
                 i, bus.dmem_req, bus.wbs_err_o, bus.dmem_wdata);
      end
    end
    @(negedge mclk);
    n_cmp++;
    if ({bus.wbs_err_o, bus.wbs_ack_o, bus.dmem_req} !== 3'b100) begin
      n_fail++;
      $display("FAIL timeout: err/ack/req=%b required 100",
               {bus.wbs_err_o, bus.wbs_ack_o, bus.dmem_req});
    end
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
    @(negedge mclk);
    n_cmp++;
    if (bus.wbs_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_pulse: err=%b required 0", bus.wbs_err_o);
    end
`else
    do_txn("stall", 1'b1, 7'h0C, 4'b1111, 32'hCAFE_F00D, 20, 0, 2'b01, 32'h0, 1'b0);
`endif
  endtask

  task automatic test_cyc_drop();
    do_txn("cyc_drop_rd", 1'b0, 7'h14, 4'b1111, 32'h0, 1, 1, 2'b01, 32'h1234_5678, 1'b1);
    do_txn("cyc_drop_err", 1'b1, 7'h14, 4'b0010, 32'h0, 0, 0, 2'b10, 32'h0, 1'b1);
  endtask

  task automatic test_reset_mid();
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0;
    bus.wbs_sel_i = 4'b1111; bus.wbs_adr_i = 7'h40; bus.wbs_dat_i = 0;
    @(negedge mclk);
    bus.dmem_req_ack = 1;
    @(negedge mclk);
    bus.dmem_req_ack = 0;
    rst = 1;
    exp_dat = '0;
    #1;
    n_cmp++;
    if ({bus.dmem_req, bus.wbs_ack_o, bus.wbs_err_o} !== 3'b000 || bus.wbs_dat_o !== exp_dat)
    begin
      n_fail++;
      $display("FAIL reset_mid: req/ack/err=%b dat=%h required 000 0",
               {bus.dmem_req, bus.wbs_ack_o, bus.wbs_err_o}, bus.wbs_dat_o);
    end
    @(negedge mclk);
    rst = 0;
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
    bus.dmem_resp = 2'b01; bus.dmem_rdata = 32'hDEAD_BEEF;
    @(negedge mclk);
    bus.dmem_resp = 2'b00;
    n_cmp++;
    if ({bus.wbs_ack_o, bus.wbs_err_o, bus.dmem_req} !== 3'b000) begin
      n_fail++;
      $display("FAIL late_resp: ack/err/req=%b required 000",
               {bus.wbs_ack_o, bus.wbs_err_o, bus.dmem_req});
    end
    do_txn("post_reset_rd", 1'b0, 7'h40, 4'b1111, 32'h0, 1, 0, 2'b01, 32'h89AB_CDEF, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] legal_tab [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    logic [1:0] code_tab  [3] = '{2'b01, 2'b10, 2'b11};
    for (int k = 0; k < 60; k++) begin
      logic [3:0] sel;
      sel = ($urandom_range(0, 3) != 0) ? legal_tab[$urandom_range(0, 6)] : 4'($urandom);
      do_txn("random", 1'($urandom), 7'($urandom), sel, $urandom,
             int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
             code_tab[$urandom_range(0, 2)], $urandom, ($urandom_range(0, 7) == 0));
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_word_write();
    test_byte_read();
    test_half_write();
    test_illegal();
    test_resp_err();
    test_stall();
    test_cyc_drop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
